// File: rtl/spike_pkg.sv
// Shared types and widths for the spike scheduler: FSM state encoding and
// the per-source register widths.
package spike_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_t;

  localparam int WEIGHT_W = 8;
  localparam int REFR_W   = 4;
  localparam int DROP_W   = 8;

endpackage

// File: rtl/spike_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping modulo N_SRC) wins; returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int N_SRC = 4,
  localparam int IW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_SRC-1:0] grant,
  output logic [IW-1:0]    idx
);

  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_SRC; k++) begin
      j = (int'(ptr) + k) % N_SRC;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spike_scheduler.sv
// Spike scheduler: captures per-neuron spikes, enforces refractory periods and
// serialises them onto one synapse port with round-robin fairness.
// Optional runtime weight writes are enabled by defining SPIKE_SCHED_WEIGHT_CFG_EN.
module spike_scheduler
  import spike_pkg::*;
#(
  parameter int                  N_SRC   = 4,
  parameter int                  REFRACT = 3,
  parameter logic [WEIGHT_W-1:0] W_INIT  = 8'h10,
  localparam int                 IW      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [N_SRC-1:0]    spike_in,
  input  logic                syn_ready,
`ifdef SPIKE_SCHED_WEIGHT_CFG_EN
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_addr,
  input  logic [WEIGHT_W-1:0] cfg_data,
`endif
  output logic                syn_valid,
  output logic [IW-1:0]       syn_src,
  output logic [WEIGHT_W-1:0] syn_weight,
  output logic [DROP_W-1:0]   drop_count,
  output logic                busy
);

  sched_state_t        state_reg, state_next;
  logic [IW-1:0]       ptr_reg, ptr_next;
  logic [IW-1:0]       syn_src_reg, syn_src_next;
  logic [WEIGHT_W-1:0] syn_weight_reg, syn_weight_next;
  logic [DROP_W-1:0]   drop_count_reg, drop_count_next;

  logic [N_SRC-1:0]    pending_vec, capture_vec, drop_vec, hs_mask, arb_req, arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any, hs;
  logic [WEIGHT_W-1:0] weight_arr [N_SRC];

  assign hs = (state_reg == OFFER) && syn_ready;

  always_comb begin
    hs_mask = '0;
    if (hs) hs_mask[syn_src_reg] = 1'b1;
  end

  // The source being accepted this cycle must not win the back-to-back grant.
  assign arb_req = pending_vec & ~hs_mask;
  assign arb_any = |arb_grant;

  rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .req   (arb_req),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    logic              pending_reg;
    logic [REFR_W-1:0] refr_reg;
    logic              refr_active;

    assign refr_active     = (refr_reg != '0);
    assign capture_vec[gi] = enable & spike_in[gi] & ~pending_reg & ~refr_active;
    assign drop_vec[gi]    = enable & spike_in[gi] & (pending_reg | refr_active);
    assign pending_vec[gi] = pending_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        pending_reg <= 1'b0;
        refr_reg    <= '0;
      end else begin
        if (hs_mask[gi])          pending_reg <= 1'b0;
        else if (capture_vec[gi]) pending_reg <= 1'b1;

        if (hs_mask[gi])      refr_reg <= REFR_W'(REFRACT);
        else if (refr_active) refr_reg <= refr_reg - REFR_W'(1);
      end
    end

`ifdef SPIKE_SCHED_WEIGHT_CFG_EN
    logic [WEIGHT_W-1:0] weight_reg;

    always_ff @(posedge clk) begin
      if (reset)                                weight_reg <= W_INIT;
      else if (cfg_we && cfg_addr == IW'(gi))   weight_reg <= cfg_data;
    end

    assign weight_arr[gi] = weight_reg;
`else
    assign weight_arr[gi] = W_INIT;
`endif
  end

  // Saturating accumulation of every spike discarded this cycle.
  logic [3:0]        drop_num;
  logic [DROP_W:0]   drop_sum;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N_SRC; i++) drop_num = drop_num + 4'(drop_vec[i]);
    drop_sum        = {1'b0, drop_count_reg} + (DROP_W + 1)'(drop_num);
    drop_count_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    syn_src_next    = syn_src_reg;
    syn_weight_next = syn_weight_reg;
    unique case (state_reg)
      IDLE: begin
        if (enable && arb_any) begin
          state_next      = OFFER;
          syn_src_next    = arb_idx;
          syn_weight_next = weight_arr[arb_idx];
          ptr_next        = (arb_idx == IW'(N_SRC - 1)) ? '0 : arb_idx + IW'(1);
        end
      end
      OFFER: begin
        if (hs) begin
          if (enable && arb_any) begin
            syn_src_next    = arb_idx;
            syn_weight_next = weight_arr[arb_idx];
            ptr_next        = (arb_idx == IW'(N_SRC - 1)) ? '0 : arb_idx + IW'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      syn_src_reg    <= '0;
      syn_weight_reg <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      syn_src_reg    <= syn_src_next;
      syn_weight_reg <= syn_weight_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign syn_valid  = (state_reg == OFFER);
  assign syn_src    = syn_src_reg;
  assign syn_weight = syn_weight_reg;
  assign drop_count = drop_count_reg;
  assign busy       = syn_valid | (|pending_vec);

endmodule
